// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, empty/full decodes and an occupancy count.
// Carries AXI burst lengths from the address-channel handlers to the beat generators.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  // Flags decode the current count only; a simultaneous push+pop at the
  // extremes is resolved by these gates, so data never bypasses the memory.
  assign w_empty   = (r_count == CNT_ZERO);
  assign w_full    = (r_count == CNT_FULL);
  assign w_push_ok = push & ~w_full;
  assign w_pop_ok  = pop & ~w_empty;

  // Storage array is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_push_ok) begin
      r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_data_out <= '0;
    end else if (w_pop_ok) begin
      r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign empty      = w_empty;
  assign full       = w_full;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4) with a queue scoreboard tracking
// expected contents, count and registered read data.
module tb_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [AW:0]   fifo_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb_q[$];
  int            m_count;
  logic [DW-1:0] m_dout;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(m_count));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".full"},  32'(full),  32'(m_count == DEPTH));
    chk({tag, ".dout"},  32'(data_out), 32'(m_dout));
  endtask

  // One clock with the given controls; the model follows the accept rules on pre-edge state.
  task automatic step(input string tag, input logic p, input logic r, input logic [DW-1:0] d);
    logic pok, rok;
    @(negedge clk);
    reset = 1'b0; push = p; pop = r; data_in = d;
    pok = p && (m_count < DEPTH);
    rok = r && (m_count > 0);
    @(posedge clk);
    #1;
    if (rok) m_dout = sb_q.pop_front();
    if (pok) sb_q.push_back(d);
    m_count = m_count + int'(pok) - int'(rok);
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic p, input logic [DW-1:0] d);
    @(negedge clk);
    reset = 1'b1; push = p; pop = 1'b0; data_in = d;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_count = 0;
    m_dout  = '0;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    m_count = 0; m_dout = '0;

    // Reset held two cycles while pushing: nothing may be stored.
    do_reset("rst0", 1'b1, 16'hAAAA);
    do_reset("rst1", 1'b1, 16'hAAAA);
    step("idle", 1'b0, 1'b0, 16'h0);
    step("pop_after_rst", 1'b0, 1'b1, 16'h0);

    // Ordered push/pop.
    step("push5", 1'b1, 1'b0, 16'd5);
    step("push3", 1'b1, 1'b0, 16'd3);
    step("push15", 1'b1, 1'b0, 16'd15);
    step("pop_a", 1'b0, 1'b1, 16'h0);
    step("pop_b", 1'b0, 1'b1, 16'h0);
    step("pop_c", 1'b0, 1'b1, 16'h0);
    chk("ordered_last", 32'(data_out), 32'd15);

    // Fill past capacity, then drain past empty.
    for (int i = 1; i <= 5; i++) step("fill", 1'b1, 1'b0, DW'(i));
    chk("full_flag", 32'(full), 32'd1);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b1, 16'h0);
    chk("drain_last", 32'(data_out), 32'd4);

    // Underflow and push+pop on empty.
    step("pop_empty", 1'b0, 1'b1, 16'h0);
    step("pushpop_empty", 1'b1, 1'b1, 16'd7);
    chk("no_bypass", 32'(data_out), 32'd4);
    step("pop7", 1'b0, 1'b1, 16'h0);
    chk("got7", 32'(data_out), 32'd7);

    // Simultaneous at mid occupancy and at full.
    step("push10", 1'b1, 1'b0, 16'd10);
    step("push11", 1'b1, 1'b0, 16'd11);
    step("pushpop_mid", 1'b1, 1'b1, 16'd12);
    chk("mid_oldest", 32'(data_out), 32'd10);
    step("push13", 1'b1, 1'b0, 16'd13);
    step("push14", 1'b1, 1'b0, 16'd14);
    step("pushpop_full", 1'b1, 1'b1, 16'd9);
    chk("full_pop_cnt", 32'(fifo_count), 32'(DEPTH - 1));
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 1'b1, 16'h0);
    chk("nine_absent", 32'(data_out), 32'd14);

    // Wrap-around: ten rounds of push-2/pop-2.
    for (int k = 0; k < 10; k++) begin
      step("wrap_push", 1'b1, 1'b0, DW'(2 * k));
      step("wrap_push", 1'b1, 1'b0, DW'(2 * k + 1));
      step("wrap_pop", 1'b0, 1'b1, 16'h0);
      chk("wrap_seq", 32'(data_out), 32'(2 * k));
      step("wrap_pop", 1'b0, 1'b1, 16'h0);
      chk("wrap_seq", 32'(data_out), 32'(2 * k + 1));
    end

    // Reset mid-operation discards contents.
    step("pre_rst_push", 1'b1, 1'b0, 16'h55);
    step("pre_rst_push", 1'b1, 1'b0, 16'h66);
    do_reset("mid_rst", 1'b0, 16'h0);
    step("post_rst_pop", 1'b0, 1'b1, 16'h0);
    step("post_rst_push", 1'b1, 1'b0, 16'h77);
    step("post_rst_pop2", 1'b0, 1'b1, 16'h0);
    chk("post_rst_data", 32'(data_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
